// File: rtl/mem_copy_pkg.sv
// Shared constants for the byte-serial memory copy engine: default widths,
// maximum copy length and the FSM state encoding.
package mem_copy_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int MAX_LEN    = 256;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_READ  = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_WRITE = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/mem_copy_engine.sv
// Byte-serial read-then-write copy master for the data memory port.
// Optional running checksum of written bytes when MEM_COPY_CHECKSUM_EN is defined.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] write_data,
`ifdef MEM_COPY_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  input  logic [DATA_W-1:0] read_data
);

  // Request protocol: start is accepted only in a cycle where busy is low;
  // busy then stays high until the cycle after the single-cycle done pulse.
  localparam logic [ADDR_W:0] MAX_CNT  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};
  localparam int              WAIT_INI = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
  localparam logic            HAS_WAIT = (READ_LATENCY > 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [1:0]        wait_q, wait_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    count_d = count_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d = '0;
          if (len != '0) begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            rem_d   = (len > MAX_CNT) ? MAX_CNT : len;
            state_d = ST_READ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_READ: begin
        wait_d  = 2'(WAIT_INI);
        state_d = HAS_WAIT ? ST_WAIT : ST_WRITE;
      end
      ST_WAIT: begin
        if (wait_q == 2'd0) state_d = ST_WRITE;
        else                wait_d  = wait_q - 2'd1;
      end
      ST_WRITE: begin
        src_d   = src_q + 1'b1;
        dst_d   = dst_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        count_d = count_q + 1'b1;
        state_d = (rem_q == ONE_CNT) ? ST_DONE : ST_READ;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      count_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      count_q <= count_d;
      wait_q  <= wait_d;
    end
  end

  // Memory data is already registered, so WRITE forwards it straight through.
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign mem_read   = (state_q == ST_READ);
  assign mem_write  = (state_q == ST_WRITE);
  assign count      = count_q;
  assign address    = (state_q == ST_READ)  ? src_q :
                      (state_q == ST_WRITE) ? dst_q : '0;
  assign write_data = (state_q == ST_WRITE) ? read_data : '0;

`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == ST_IDLE && start)  csum_d = '0;
    else if (state_q == ST_WRITE)     csum_d = csum_q + read_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: two instances (read latency 1 and 3), each on its own
// behavioural memory, checked cycle by cycle against a trace built from copy semantics.
module tb_mem_copy_engine;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wd;
    logic [8:0] count;
    logic [7:0] csum;
  } obs_t;

  localparam int OBS_W = $bits(obs_t);

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start_i [2];
  logic [7:0] src_i   [2];
  logic [7:0] dst_i   [2];
  logic [8:0] len_i   [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  logic       rd_o    [2];
  logic       wr_o    [2];
  logic [8:0] count_o [2];
  logic [7:0] addr_o  [2];
  logic [7:0] wd_o    [2];
  logic [7:0] rdata_i [2];
`ifdef MEM_COPY_CHECKSUM_EN
  logic [7:0] csum_o  [2];
`endif

  mem_copy_engine #(.ADDR_W(8), .DATA_W(8), .READ_LATENCY(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .src_addr(src_i[0]),
    .dst_addr(dst_i[0]), .len(len_i[0]), .busy(busy_o[0]), .done(done_o[0]),
    .count(count_o[0]), .address(addr_o[0]), .mem_read(rd_o[0]),
    .mem_write(wr_o[0]), .write_data(wd_o[0]),
`ifdef MEM_COPY_CHECKSUM_EN
    .checksum(csum_o[0]),
`endif
    .read_data(rdata_i[0])
  );

  mem_copy_engine #(.ADDR_W(8), .DATA_W(8), .READ_LATENCY(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .src_addr(src_i[1]),
    .dst_addr(dst_i[1]), .len(len_i[1]), .busy(busy_o[1]), .done(done_o[1]),
    .count(count_o[1]), .address(addr_o[1]), .mem_read(rd_o[1]),
    .mem_write(wr_o[1]), .write_data(wd_o[1]),
`ifdef MEM_COPY_CHECKSUM_EN
    .checksum(csum_o[1]),
`endif
    .read_data(rdata_i[1])
  );

  // Memories with registered read data delayed by the instance's latency.
  logic       mem_init;
  logic [7:0] mem  [2][256];
  logic [7:0] pipe [2][4];
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (mem_init) begin
        for (int k = 0; k < 256; k++) mem[g][k] <= 8'(k);
      end else if (wr_o[g]) begin
        mem[g][addr_o[g]] <= wd_o[g];
      end
      pipe[g][0] <= rd_o[g] ? mem[g][addr_o[g]] : 8'h00;
      for (int k = 1; k < 4; k++) pipe[g][k] <= pipe[g][k-1];
    end
  end
  assign rdata_i[0] = pipe[0][0];
  assign rdata_i[1] = pipe[1][2];

  // scoreboard state
  logic [OBS_W-1:0] exp_q [$];
  obs_t       idle_obs [2];
  logic [7:0] refmem   [2][256];
  logic [7:0] plan_mem [2][256];
  int lane = 0;
  int checks = 0;
  int errors = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  function automatic int rl(input int ln);
    return (ln == 0) ? 1 : 3;
  endfunction

  function automatic obs_t mk(input logic b, input logic dn, input logic r, input logic w,
                              input logic [7:0] ad, input logic [7:0] wd,
                              input logic [8:0] c, input logic [7:0] cs);
    obs_t o;
    o.busy = b; o.done = dn; o.rd = r; o.wr = w;
    o.addr = ad; o.wd = wd; o.count = c; o.csum = cs;
    return o;
  endfunction

  function automatic obs_t act_of(input int ln);
    obs_t o;
    o = mk(busy_o[ln], done_o[ln], rd_o[ln], wr_o[ln], addr_o[ln], wd_o[ln], count_o[ln], 8'h00);
`ifdef MEM_COPY_CHECKSUM_EN
    o.csum = csum_o[ln];
`endif
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic compare_step();
    obs_t e;
    obs_t a;
    if (mem_init) begin
      for (int g = 0; g < 2; g++) begin
        for (int k = 0; k < 256; k++) refmem[g][k] = 8'(k);
        idle_obs[g] = '0;
      end
    end else if (!rst_n) begin
      exp_q.delete();
      idle_obs[0] = '0;
      idle_obs[1] = '0;
    end else begin
      if (exp_q.size() > 0) e = obs_t'(exp_q.pop_front());
      else                  e = idle_obs[lane];
`ifndef MEM_COPY_CHECKSUM_EN
      e.csum = 8'h00;
`endif
      a = act_of(lane);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL trace lane=%0d cyc=%0d got=%h expected=%h", lane, cyc, a, e);
      end
      if (e.wr) refmem[lane][e.addr] = e.wd;
      if (e.done) begin
        idle_obs[lane] = e;
        idle_obs[lane].busy = 1'b0;
        idle_obs[lane].done = 1'b0;
      end
      if (a.done) begin done_cnt++; done_cyc = cyc - start_cyc; end
      if (a.wr) wr_cnt++;
      if (a.rd) rd_cnt++;
    end
  endtask

  // driver: pulse start and append the full expected per-cycle trace of the copy
  task automatic launch(input int ln, input logic [7:0] s, input logic [7:0] d, input logic [8:0] n);
    int nn;
    logic [7:0] sum, v, sa, da;
    @(negedge clk); #1;
    lane = ln;
    src_i[ln] = s; dst_i[ln] = d; len_i[ln] = n; start_i[ln] = 1'b1;
    start_cyc = cyc;
    nn = (n > 9'd256) ? 256 : int'(n);
    sum = 8'h00;
    for (int i = 0; i < nn; i++) begin
      sa = s + 8'(i);
      da = d + 8'(i);
      v  = plan_mem[ln][sa];
      plan_mem[ln][da] = v;
      exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, sa, 8'h00, 9'(i), sum));
      for (int w = 0; w < rl(ln) - 1; w++)
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 9'(i), sum));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, da, v, 9'(i), sum));
      sum = sum + v;
    end
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 9'(nn), sum));
    @(negedge clk); #1;
    start_i[ln] = 1'b0;
  endtask

  task automatic compare_mem(input int ln);
    int bad = 0;
    for (int k = 0; k < 256; k++) if (mem[ln][k] !== refmem[ln][k]) bad++;
    chk($sformatf("mem_image_lane%0d", ln), bad, 0);
  endtask

  task automatic finish_copy();
    wait (exp_q.size() == 0);
    @(negedge clk); #1;
    compare_mem(lane);
  endtask

  task automatic run_copy(input int ln, input logic [7:0] s, input logic [7:0] d, input logic [8:0] n);
    launch(ln, s, d, n);
    finish_copy();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cyc=%0d expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    int d0, w0, r0;
    obs_t a;
    rst_n = 1'b0;
    mem_init = 1'b1;
    for (int g = 0; g < 2; g++) begin
      start_i[g] = 1'b0; src_i[g] = '0; dst_i[g] = '0; len_i[g] = '0;
      for (int k = 0; k < 256; k++) plan_mem[g][k] = 8'(k);
    end
    fork
      forever begin
        @(negedge clk);
        compare_step();
      end
    join_none
    repeat (2) @(negedge clk);
    #1 mem_init = 1'b0;
    for (int g = 0; g < 2; g++) begin
      a = act_of(g);
      chk($sformatf("reset_outputs_l%0d", g), 32'({a.busy, a.done, a.rd, a.wr, a.addr, a.wd, a.count, a.csum}), 0);
    end
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk);

    // basic copy, latency 1
    d0 = done_cnt;
    run_copy(0, 8'h10, 8'h80, 9'd3);
    chk("t1_mem80", mem[0][8'h80], 8'h10);
    chk("t1_mem81", mem[0][8'h81], 8'h11);
    chk("t1_mem82", mem[0][8'h82], 8'h12);
    chk("t1_done_cycle", done_cyc, 7);
    chk("t1_count", count_o[0], 3);
    chk("t1_done_pulses", done_cnt - d0, 1);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("t1_checksum", csum_o[0], 8'h33);
`endif

    // source pointer wraps 0xFF -> 0x00
    run_copy(0, 8'hFE, 8'h40, 9'd4);
    chk("t2_mem40", mem[0][8'h40], 8'hFE);
    chk("t2_mem41", mem[0][8'h41], 8'hFF);
    chk("t2_mem42", mem[0][8'h42], 8'h00);
    chk("t2_mem43", mem[0][8'h43], 8'h01);

    // zero length: no memory access
    w0 = wr_cnt; r0 = rd_cnt;
    run_copy(0, 8'h33, 8'h44, 9'd0);
    chk("t3_writes", wr_cnt - w0, 0);
    chk("t3_reads", rd_cnt - r0, 0);
    chk("t3_done_cycle", done_cyc, 1);
    chk("t3_count", count_o[0], 0);

    // async reset during the third READ of a 5-byte copy
    launch(0, 8'h20, 8'h60, 9'd5);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    a = act_of(0);
    chk("t6_async_reset", 32'({a.busy, a.done, a.rd, a.wr, a.addr, a.wd, a.count, a.csum}), 0);
    for (int k = 0; k < 256; k++) plan_mem[0][k] = refmem[0][k];
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("t6_mem60", mem[0][8'h60], 8'h20);
    chk("t6_mem61", mem[0][8'h61], 8'h21);
    chk("t6_mem62", mem[0][8'h62], 8'h62);
    run_copy(0, 8'h70, 8'h62, 9'd2);
    chk("t6_after_mem62", mem[0][8'h62], 8'h70);
    chk("t6_after_mem63", mem[0][8'h63], 8'h71);

    // latency 3 with a start pulse while busy
    launch(1, 8'h30, 8'h90, 9'd2);
    @(negedge clk); #1;
    src_i[1] = 8'h00; len_i[1] = 9'd7; start_i[1] = 1'b1;
    @(negedge clk); #1;
    start_i[1] = 1'b0;
    finish_copy();
    chk("t5_done_cycle", done_cyc, 9);
    chk("t5_mem90", mem[1][8'h90], 8'h30);
    chk("t5_mem91", mem[1][8'h91], 8'h31);

    // oversized length saturates to 256
    d0 = done_cnt; w0 = wr_cnt;
    run_copy(0, 8'h05, 8'h85, 9'd300);
    chk("t4_writes", wr_cnt - w0, 256);
    chk("t4_count", count_o[0], 256);
    chk("t4_done_pulses", done_cnt - d0, 1);

    // randomized copies on both instances
    for (int t = 0; t < 12; t++)
      run_copy(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 9'($urandom_range(0, 40)));
    run_copy(1, 8'($urandom), 8'($urandom), 9'($urandom_range(257, 511)));
    compare_mem(0);
    compare_mem(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Initiator-side master for the 256-byte data memory: drives `address`, `mem_read`, `mem_write` and `write_data`, and consumes the memory's registered `read_data`.
- Copies `len` bytes from `src_addr` to `dst_addr` one byte at a time in a read-then-write sequence.
- Sits between the control/CPU path and the data memory.
- Used for block moves and memory initialisation; it is the only master on that memory port while `busy` is high.

Parameters:
- ADDR_W, 8, memory address width; pointers wrap modulo 2^ADDR_W.
- DATA_W, 8, data byte width.
- READ_LATENCY, 1, cycles from `mem_read` asserted to `read_data` valid; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  copy request; sampled in IDLE only.
- src_addr  in  ADDR_W  first source byte address.
- dst_addr  in  ADDR_W  first destination byte address.
- len  in  ADDR_W+1  byte count, 0..256; values >256 saturate to 256.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when the copy completes.
- count  out  ADDR_W+1  bytes written so far in the current or last copy.
- address  out  ADDR_W  memory address.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- write_data  out  DATA_W  memory write data.
- read_data  in  DATA_W  registered memory read data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, mem_read, mem_write = 0.
  - address, write_data, count = 0.
  - Internal pointers and remaining-count cleared.
- Reset mid-copy aborts immediately. Bytes already written stay in memory; no partial write is issued.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE:
  - start=1 with len!=0: latch src/dst pointers, remaining=min(len,256), count=0; go to READ.
  - start=1 with len==0: go to DONE with no memory access.
  - start in any other state is ignored.
- READ (1 cycle): address=src_ptr, mem_read=1. Next state is WAIT if READ_LATENCY>1, else WRITE.
- WAIT: stays for READ_LATENCY-1 cycles, counted by a wait counter; all strobes low.
- WRITE (1 cycle):
  - address=dst_ptr, mem_write=1, write_data=read_data (direct pass-through; `read_data` is registered in memory).
  - On exit: src_ptr+1, dst_ptr+1 (both wrap 0xFF→0x00), remaining-1, count+1.
  - Next state is DONE if remaining reaches 0, else READ.
- DONE (1 cycle): done=1, then IDLE unconditionally.
- Outputs are Moore-decoded from the state and pointer registers. Outside READ/WRITE: address=0, write_data=0.
- mem_read and mem_write are never high in the same cycle.
- Throughput: one byte per READ_LATENCY+1 cycles.
- Timing: start sampled at edge E0 gives READ in cycle 1. DONE occurs in cycle N*(READ_LATENCY+1)+1.
- Overlap: the copy is strictly forward and byte-serial. If dst lies within (src, src+len), earlier writes are re-read and propagate; this is defined behaviour.
- count holds its final value in IDLE until the next accepted start.

Optional Feature:
- Macro MEM_COPY_CHECKSUM_EN.
- Defined:
  - Adds output `checksum [DATA_W-1:0]`: modulo-2^DATA_W sum of every byte written.
  - Cleared on start acceptance and on reset.
  - Updated in WRITE; valid when done=1 and held in IDLE.
- Undefined: port and adder are absent; all other behaviour is identical.

Decomposition:
- Package mem_copy_pkg holds:
  - State enum (IDLE, READ, WAIT, WRITE, DONE).
  - ADDR_W/DATA_W default constants.
  - MAX_LEN=256.
- No sub-module required. Pointer/remaining logic stays inline; the FSM is small enough for one module.

Test Plan:
- Memory initialised with data=address. src=0x10, dst=0x80, len=3, READ_LATENCY=1 → after the run, mem[0x80..0x82]=0x10,0x11,0x12; done pulses in cycle 7; count=3; checksum=0x33 when enabled.
- src=0xFE, dst=0x40, len=4 → reads addresses FE, FF, 00, 01; mem[0x40..0x43]=0xFE,0xFF,0x00,0x01.
- len=0 → no mem_read/mem_write ever asserted; done pulses in cycle 1; count=0.
- len=300 → exactly 256 writes; count=256; one done pulse.
- READ_LATENCY=3, len=2 → each WRITE is 3 cycles after its READ; done in cycle 9; start pulsed while busy has no effect.
- rst_n pulled low after the second WRITE of a len=5 copy → all outputs 0 asynchronously; only dst+0 and dst+1 modified; the next start runs normally.
